// File: rtl/alarm_scheduler.sv
// alarm_scheduler: debounces four sensor inputs, latches new alarms as
// pending, and announces them one at a time on a shared buzzer, highest
// index first. Each acknowledge is followed by a quiet hold-off window.
// Optional feature macro: ALARM_ESCALATE_EN adds an escalation flag that
// rises when an alert has gone unacknowledged for ESCALATE_CYCLES cycles.
//
// state | meaning
// IDLE  | nothing announced; start an alert when anything is pending
// ALERT | announcing active_id, buzzer beeping
// HOLD  | quiet window after an acknowledge
module alarm_scheduler #(
  parameter int DEBOUNCE        = 4,
  parameter int BEEP_HALF       = 2,
  parameter int HOLDOFF         = 8,
  parameter int ESCALATE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  input  logic       ack,
  output logic       buzzer,
  output logic       alarm_valid,
  output logic [1:0] active_id,
  output logic [3:0] pending,
  output logic       escalate
);

  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int BEEP_W = $clog2(BEEP_HALF + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  if (DEBOUNCE < 1 || BEEP_HALF < 1 || HOLDOFF < 1 || ESCALATE_CYCLES < 1) begin : g_param_check
    $error("alarm_scheduler: timing parameters must all be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ALERT, HOLD} state_t;

  state_t            state, state_n;
  logic [DB_W-1:0]   db_cnt [4];
  logic [3:0]        stable, stable_q, rise, clr;
  logic [1:0]        hi_id, id_n;
  logic [BEEP_W-1:0] beep_cnt, beep_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              buz_n, valid_n, preempt;

  // Per-bit debounce; the counter saturates once the input is declared stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      stable   <= '0;
      stable_q <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (!sensor[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= 1'b0;
        end else if (db_cnt[i] != DB_W'(DEBOUNCE)) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
          if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) stable[i] <= 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_q;

  // Highest-index pending source.
  always_comb begin
    hi_id = 2'd0;
    for (int i = 0; i < 4; i++) if (pending[i]) hi_id = 2'(i);
  end

  assign preempt = (state == ALERT) && !ack && (hi_id > active_id);

  // Next-state and next-output decode; an acknowledge outranks a preemption.
  always_comb begin
    state_n = state;
    id_n    = active_id;
    buz_n   = 1'b0;
    valid_n = 1'b0;
    beep_n  = beep_cnt;
    hold_n  = hold_cnt;
    clr     = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_n = ALERT;
          id_n    = hi_id;
          buz_n   = 1'b1;
          valid_n = 1'b1;
          beep_n  = BEEP_W'(BEEP_HALF - 1);
        end
      end
      ALERT: begin
        valid_n = 1'b1;
        buz_n   = buzzer;
        if (ack) begin
          clr[active_id] = 1'b1;
          state_n = HOLD;
          hold_n  = HOLD_W'(HOLDOFF - 1);
          valid_n = 1'b0;
          buz_n   = 1'b0;
        end else if (preempt) begin
          id_n   = hi_id;
          buz_n  = 1'b1;
          beep_n = BEEP_W'(BEEP_HALF - 1);
        end else if (beep_cnt == '0) begin
          buz_n  = ~buzzer;
          beep_n = BEEP_W'(BEEP_HALF - 1);
        end else begin
          beep_n = beep_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_n = IDLE;
        else hold_n = hold_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, output and pending registers; a new rise beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      active_id   <= 2'd0;
      buzzer      <= 1'b0;
      alarm_valid <= 1'b0;
      beep_cnt    <= '0;
      hold_cnt    <= '0;
      pending     <= '0;
    end else begin
      state       <= state_n;
      active_id   <= id_n;
      buzzer      <= buz_n;
      alarm_valid <= valid_n;
      beep_cnt    <= beep_n;
      hold_cnt    <= hold_n;
      pending     <= (pending & ~clr) | rise;
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam int ESC_W = $clog2(ESCALATE_CYCLES + 1);
  logic [ESC_W-1:0] esc_cnt;

  // Escalation timer: reloads on alert entry or preemption, flag sticks until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_cnt  <= '0;
      escalate <= 1'b0;
    end else if (state == ALERT) begin
      if (ack) escalate <= 1'b0;
      else if (preempt) esc_cnt <= ESC_W'(ESCALATE_CYCLES - 1);
      else if (esc_cnt == '0) escalate <= 1'b1;
      else esc_cnt <= esc_cnt - 1'b1;
    end else if (state == IDLE && |pending) begin
      esc_cnt <= ESC_W'(ESCALATE_CYCLES - 1);
    end
  end
`else
  assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scenario bench for alarm_scheduler. Each scenario pushes the expected
// output snapshots {alarm_valid, buzzer, active_id, pending, escalate}
// tagged with the cycle they are due, then drives stimulus and compares
// against the queue as the DUT reaches each tagged cycle.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sensor = 4'b0;
  logic       ack = 1'b0;
  logic       buzzer, alarm_valid, escalate;
  logic [1:0] active_id;
  logic [3:0] pending;

  alarm_scheduler dut (
    .clk(clk), .rst(rst), .sensor(sensor), .ack(ack),
    .buzzer(buzzer), .alarm_valid(alarm_valid), .active_id(active_id),
    .pending(pending), .escalate(escalate)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [8:0] v; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

`ifdef ALARM_ESCALATE_EN
  localparam logic ESC_EXP = 1'b1;
`else
  localparam logic ESC_EXP = 1'b0;
`endif

  logic [8:0] obs;
  assign obs = {alarm_valid, buzzer, active_id, pending, escalate};

  function automatic logic [8:0] pk(logic va, logic bz, logic [1:0] id, logic [3:0] pd, logic es);
    return {va, bz, id, pd, es};
  endfunction

  function automatic exp_t ex(int t, logic [8:0] v);
    exp_t e;
    e.t = t;
    e.v = v;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; sensor = 4'b0; ack = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; sensor = 4'hF; ack = 1'b1;
    for (int t = 1; t <= 5; t++) sb.push_back(ex(t, 9'b0));
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL reset t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
  endtask

  task automatic test_rain();
    exp_t e;
    do_reset();
    sb.push_back(ex(4,  pk(0, 0, 2'd0, 4'b0000, 0)));
    sb.push_back(ex(5,  pk(0, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(6,  pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(7,  pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(8,  pk(1, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(9,  pk(1, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(10, pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(19, pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(20, pk(0, 0, 2'd0, 4'b0000, 0)));
    sb.push_back(ex(27, pk(0, 0, 2'd0, 4'b0000, 0)));
    sb.push_back(ex(29, pk(0, 0, 2'd0, 4'b0000, 0)));
    for (int t = 1; t <= 30; t++) begin
      sensor = (t <= 10) ? 4'b0001 : 4'b0000;
      ack = (t == 20);
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL rain t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_glitch();
    exp_t e;
    do_reset();
    sb.push_back(ex(3,  9'b0));
    sb.push_back(ex(4,  9'b0));
    sb.push_back(ex(7,  9'b0));
    sb.push_back(ex(8,  9'b0));
    sb.push_back(ex(12, 9'b0));
    sb.push_back(ex(23, 9'b0));
    sb.push_back(ex(24, pk(0, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(25, pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(30, pk(0, 0, 2'd0, 4'b0000, 0)));
    for (int t = 1; t <= 32; t++) begin
      sensor = ((t >= 1 && t <= 3) || (t >= 5 && t <= 7) || (t >= 20 && t <= 23)) ? 4'b0001 : 4'b0000;
      ack = (t == 30);
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL glitch t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_preempt();
    exp_t e;
    do_reset();
    sb.push_back(ex(6,  pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(12, pk(1, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(13, pk(1, 0, 2'd0, 4'b1001, 0)));
    sb.push_back(ex(14, pk(1, 1, 2'd3, 4'b1001, 0)));
    sb.push_back(ex(15, pk(1, 1, 2'd3, 4'b1001, 0)));
    sb.push_back(ex(16, pk(1, 0, 2'd3, 4'b1001, 0)));
    sb.push_back(ex(18, pk(0, 0, 2'd3, 4'b0001, 0)));
    sb.push_back(ex(25, pk(0, 0, 2'd3, 4'b0001, 0)));
    sb.push_back(ex(26, pk(0, 0, 2'd3, 4'b0001, 0)));
    sb.push_back(ex(27, pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(28, pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(29, pk(1, 0, 2'd0, 4'b0001, 0)));
    for (int t = 1; t <= 29; t++) begin
      sensor = {(t >= 9), 2'b00, 1'b1};
      ack = (t == 18);
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL preempt t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_ack();
    exp_t e;
    do_reset();
    sb.push_back(ex(3,  9'b0));
    sb.push_back(ex(8,  9'b0));
    sb.push_back(ex(9,  pk(0, 0, 2'd0, 4'b0110, 0)));
    sb.push_back(ex(10, pk(1, 1, 2'd2, 4'b0110, 0)));
    sb.push_back(ex(11, pk(1, 1, 2'd2, 4'b0110, 0)));
    sb.push_back(ex(12, pk(0, 0, 2'd2, 4'b0010, 0)));
    sb.push_back(ex(19, pk(0, 0, 2'd2, 4'b0010, 0)));
    sb.push_back(ex(20, pk(0, 0, 2'd2, 4'b0010, 0)));
    sb.push_back(ex(21, pk(1, 1, 2'd1, 4'b0010, 0)));
    sb.push_back(ex(22, pk(0, 0, 2'd1, 4'b0000, 0)));
    sb.push_back(ex(30, pk(0, 0, 2'd1, 4'b0000, 0)));
    sb.push_back(ex(35, pk(0, 0, 2'd1, 4'b0000, 0)));
    for (int t = 1; t <= 36; t++) begin
      sensor = (t >= 5 && t <= 12) ? 4'b0110 : 4'b0000;
      ack = (t <= 3) || (t >= 12 && t <= 31);
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL ack t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_alert();
    exp_t e;
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      sb.push_back(ex(4, 9'b0));
      sb.push_back(ex(5, pk(0, 0, 2'd0, 4'b1010, 0)));
      sb.push_back(ex(6, pk(1, 1, 2'd3, 4'b1010, 0)));
      sb.push_back(ex(8, pk(1, 0, 2'd3, 4'b1010, 0)));
      for (int t = 1; t <= 10; t++) begin
        sensor = 4'b1010;
        @(posedge clk); @(negedge clk);
        while (sb.size() > 0 && sb[0].t == t) begin
          e = sb.pop_front();
          n_checks++;
          if (obs !== e.v) begin
            n_fail++;
            $display("FAIL rst_mid ph=%0d t=%0d got=%b exp=%b", ph, t, obs, e.v);
          end
        end
      end
      if (ph == 0) begin
        #2 rst = 1'b1;
        sb.push_back(ex(0, 9'b0));
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL rst_async got=%b exp=%b", obs, e.v);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
      end
    end
    sensor = 4'b0;
  endtask

  task automatic test_escalate();
    exp_t e;
    do_reset();
    sb.push_back(ex(6,  pk(1, 1, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(69, pk(1, 0, 2'd0, 4'b0001, 0)));
    sb.push_back(ex(70, pk(1, 1, 2'd0, 4'b0001, ESC_EXP)));
    sb.push_back(ex(71, pk(1, 1, 2'd0, 4'b0001, ESC_EXP)));
    sb.push_back(ex(72, pk(0, 0, 2'd0, 4'b0000, 0)));
    sb.push_back(ex(75, pk(0, 0, 2'd0, 4'b0000, 0)));
    for (int t = 1; t <= 76; t++) begin
      sensor = 4'b0001;
      ack = (t == 72);
      @(posedge clk); @(negedge clk);
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        n_checks++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL escalate t=%0d got=%b exp=%b", t, obs, e.v);
        end
      end
    end
    ack = 1'b0;
    sensor = 4'b0;
  endtask

  initial begin
    test_reset();
    test_rain();
    test_glitch();
    test_preempt();
    test_ack();
    test_reset_mid_alert();
    test_escalate();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover %0d expectations never reached", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter DEBOUNCE, default 4, consecutive high cycles before a sensor counts as asserted.
REQ-002 Parameter BEEP_HALF, default 2, buzzer half-period in cycles.
REQ-003 Parameter HOLDOFF, default 8, quiet cycles after each acknowledge.
REQ-004 Parameter ESCALATE_CYCLES, default 64, unacknowledged-alert cycles before escalation.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-007 sensor  input  4  raw sensor levels; bit3 fire, bit2 gas, bit1 intruder, bit0 rain.
REQ-008 ack  input  1  user acknowledge of the current alert, sampled per cycle.
REQ-009 buzzer  output  1  shared buzzer drive.
REQ-010 alarm_valid  output  1  high while an alert is being announced.
REQ-011 active_id  output  2  index of the alert being announced (3 = fire ... 0 = rain).
REQ-012 pending  output  4  latched, unserviced alarm sources.
REQ-013 escalate  output  1  unacknowledged-alert escalation flag.

Function
REQ-014 Per-bit debounce: stable[i] rises after sensor[i] high for DEBOUNCE consecutive cycles; any low cycle clears stable[i] and its counter at once.
REQ-015 pending[i] set on the cycle after a 0->1 transition of stable[i]; a source held high sets pending only once.
REQ-016 FSM states IDLE, ALERT, HOLD; reset state IDLE.
REQ-017 IDLE: buzzer=0, alarm_valid=0; if pending!=0, go ALERT next cycle with active_id = highest-index pending bit.
REQ-018 ALERT: alarm_valid=1; buzzer=1 for BEEP_HALF cycles, 0 for BEEP_HALF cycles, repeating, starting high on ALERT entry.
REQ-019 ALERT preemption: a pending bit higher than active_id switches active_id next cycle, restarts the beep phase and the escalation counter; the preempted bit stays pending.
REQ-020 ALERT + ack=1: clear pending[active_id], go HOLD next cycle; buzzer=0 and alarm_valid=0 from that cycle.
REQ-021 HOLD: buzzer=0, alarm_valid=0 for exactly HOLDOFF cycles, then IDLE; new pending bits still latch during HOLD.
REQ-022 ack outside ALERT ignored; ack held high across multiple cycles clears only one source per ALERT entry.
REQ-023 Same-cycle set and clear of one pending bit: set wins, bit remains 1.
REQ-024 active_id holds its last value outside ALERT.
REQ-025 All outputs registered; latency raw sensor edge -> alarm_valid = DEBOUNCE+2 cycles from IDLE.

Reset
REQ-026 rst=1 asynchronously forces IDLE, buzzer=0, alarm_valid=0, active_id=0, pending=0, escalate=0, all counters and stable bits 0.
REQ-027 rst asserted mid-ALERT or mid-HOLD discards all pending alarms; sensors still high re-debounce from zero after release.

Configuration
REQ-028 Macro ALARM_ESCALATE_EN defined: escalate rises after ESCALATE_CYCLES consecutive ALERT cycles without ack, holds until ack in ALERT or reset.
REQ-029 ALARM_ESCALATE_EN undefined: escalate constant 0, escalation counter absent; all other behaviour identical.

Verification
REQ-030 rain (bit0) high 10 cycles from reset -> pending=0001 after 5 cycles, alarm_valid=1 at cycle 6, active_id=0, buzzer 1,1,0,0,1...
REQ-031 rain pulse high 3 cycles then low -> pending stays 0000, buzzer never high.
REQ-032 rain alerting, then fire high 4+ cycles -> active_id 0->3, beep restarts, pending=1001; ack -> pending=0001, HOLD 8 cycles, then rain re-announced.
REQ-033 ack while IDLE, and ack held 20 cycles across two queued alerts -> only one source cleared per ALERT entry.
REQ-034 rst pulsed mid-ALERT with pending=1010 -> all outputs 0 immediately, no alert until sensors re-debounce.
REQ-035 ALARM_ESCALATE_EN defined, no ack for 64 ALERT cycles -> escalate=1 at cycle 64, cleared by ack; undefined -> escalate stays 0.
